// File: rtl/uart_core_p_if.sv
// Handshake bundle between uart_core_p and the command parser / result formatter.
// The core takes the slave modport; the byte producer/consumer takes master.
interface uart_core_p_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_parity_err;
   logic                 rx_overrun;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
   );
endinterface

// File: rtl/uart_core_p.sv
// Parametrised UART: configurable width/parity/stop bits, oversampled 2-of-3 voting RX.
// Optional macro UART_LOOPBACK_EN adds a loopback port routing TX into RX internally.
module uart_core_p #(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         rx,
   output logic         tx,
   uart_core_p_if.slave bus
`ifdef UART_LOOPBACK_EN
   ,input logic         loopback
`endif
);

   localparam int DIV_RAW = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HALF    = OVERSAMPLE / 2;
   localparam int OS_W    = $clog2(OVERSAMPLE);
   localparam int TXC_W   = $clog2(STOP_BITS * OVERSAMPLE + 1);
   localparam int BIT_W   = $clog2(DATA_BITS);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

   // Expected parity bit for a payload: even = XOR of data, odd = inverted.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY == 1);
   endfunction

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic             tx_q;
   logic             rx_src;

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

`ifdef UART_LOOPBACK_EN
   assign tx     = loopback ? 1'b1 : tx_q;
   assign rx_src = loopback ? tx_q : rx;
`else
   assign tx     = tx_q;
   assign rx_src = rx;
`endif

   // ---------------- transmitter ----------------
   uart_state_t          tx_state, tx_next;
   logic [TXC_W-1:0]     tx_cnt;
   logic [DATA_BITS-1:0] tx_shreg;
   logic [BIT_W-1:0]     tx_bit;
   logic                 tx_par;
   logic                 tx_en;
   logic                 tx_accept;
   logic                 tx_bit_end;

   assign bus.tx_ready = tx_en && (tx_state == ST_IDLE);
   assign tx_accept    = bus.tx_valid && bus.tx_ready;
   assign tx_bit_end   = tick && ((tx_state == ST_STOP) ? (tx_cnt == TXC_W'(STOP_BITS * OVERSAMPLE))
                                                        : (tx_cnt == TXC_W'(OVERSAMPLE)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tx_state <= ST_IDLE;
      else          tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         ST_IDLE:   if (tx_accept) tx_next = ST_START;
         ST_START:  if (tx_bit_end) tx_next = ST_DATA;
         ST_DATA:   if (tx_bit_end && tx_bit == BIT_W'(DATA_BITS - 1))
                       tx_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (tx_bit_end) tx_next = ST_STOP;
         ST_STOP:   if (tx_bit_end) tx_next = ST_IDLE;
         default:   tx_next = ST_IDLE;
      endcase
   end

   // A start accepted off-tick holds the line high (tx_cnt==0) until the first tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_cnt   <= '0;
         tx_shreg <= '0;
         tx_bit   <= '0;
         tx_par   <= 1'b0;
         tx_q     <= 1'b1;
         tx_en    <= 1'b0;
      end else begin
         tx_en <= 1'b1;
         if (tx_state == ST_IDLE) begin
            tx_q <= 1'b1;
            if (tx_accept) begin
               tx_shreg <= bus.tx_data;
               tx_par   <= parity_of(bus.tx_data);
               tx_bit   <= '0;
               tx_cnt   <= tick ? TXC_W'(1) : '0;
               tx_q     <= !tick;
            end
         end else if (tick) begin
            if (tx_cnt == '0) begin
               tx_cnt <= TXC_W'(1);
               tx_q   <= 1'b0;
            end else if (tx_bit_end) begin
               tx_cnt <= TXC_W'(1);
               unique case (tx_next)
                  ST_DATA: begin
                     if (tx_state == ST_DATA) begin
                        tx_shreg <= tx_shreg >> 1;
                        tx_q     <= tx_shreg[1];
                        tx_bit   <= tx_bit + 1'b1;
                     end else begin
                        tx_q <= tx_shreg[0];
                     end
                  end
                  ST_PARITY: tx_q <= tx_par;
                  default:   tx_q <= 1'b1;
               endcase
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
         end
      end
   end

   // ---------------- receiver ----------------
   logic                 rx_p0, rx_p1, rx_p2;
   uart_state_t          rx_state, rx_next;
   logic [OS_W-1:0]      rx_cnt;
   logic [1:0]           rx_smp;
   logic [DATA_BITS-1:0] rx_shreg;
   logic [BIT_W-1:0]     rx_bit;
   logic                 rx_par_bit;
   logic                 rx_fall;
   logic                 rx_vote_tick;
   logic                 rx_vote;

   // Synchroniser (p0, p1) plus one history flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_p0 <= 1'b0;
         rx_p1 <= 1'b0;
         rx_p2 <= 1'b0;
      end else begin
         rx_p0 <= rx_src;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   assign rx_fall      = rx_p2 && !rx_p1;
   assign rx_vote_tick = tick && (rx_state != ST_IDLE) && (rx_cnt == OS_W'(HALF + 1));
   assign rx_vote      = vote3(rx_smp[0], rx_smp[1], rx_p1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rx_state <= ST_IDLE;
      else          rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         ST_IDLE:   if (rx_fall) rx_next = ST_START;
         ST_START:  if (rx_vote_tick) rx_next = rx_vote ? ST_IDLE : ST_DATA;
         ST_DATA:   if (rx_vote_tick && rx_bit == BIT_W'(DATA_BITS - 1))
                       rx_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (rx_vote_tick) rx_next = ST_STOP;
         ST_STOP:   if (rx_vote_tick) rx_next = ST_IDLE;
         default:   rx_next = ST_IDLE;
      endcase
   end

   // States name the bit whose vote is pending; rx_cnt free-runs modulo OVERSAMPLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_cnt            <= '0;
         rx_smp            <= '0;
         rx_shreg          <= '0;
         rx_bit            <= '0;
         rx_par_bit        <= 1'b0;
         bus.rx_data       <= '0;
         bus.rx_valid      <= 1'b0;
         bus.rx_frame_err  <= 1'b0;
         bus.rx_parity_err <= 1'b0;
         bus.rx_overrun    <= 1'b0;
      end else begin
         bus.rx_frame_err  <= 1'b0;
         bus.rx_parity_err <= 1'b0;
         bus.rx_overrun    <= 1'b0;
         if (rx_state == ST_IDLE) begin
            rx_cnt <= '0;
            rx_bit <= '0;
         end else if (tick) begin
            rx_cnt <= (rx_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : rx_cnt + 1'b1;
            if (rx_cnt == OS_W'(HALF - 1)) rx_smp[0] <= rx_p1;
            if (rx_cnt == OS_W'(HALF))     rx_smp[1] <= rx_p1;
         end
         if (rx_vote_tick && rx_state == ST_DATA) begin
            rx_shreg <= {rx_vote, rx_shreg[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
         if (rx_vote_tick && rx_state == ST_PARITY) rx_par_bit <= rx_vote;
         if (rx_vote_tick && rx_state == ST_STOP) begin
            bus.rx_frame_err  <= !rx_vote;
            bus.rx_parity_err <= (PARITY != 0) && (rx_par_bit != parity_of(rx_shreg));
            if (bus.rx_valid && !bus.rx_ready) begin
               bus.rx_overrun <= 1'b1;
            end else begin
               bus.rx_data  <= rx_shreg;
               bus.rx_valid <= 1'b1;
            end
         end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_core_p.sv
// Bench for uart_core_p: an 8N1 instance (A) and an 8E2 instance (B), DIV=1, 8 clk per bit.
`timescale 1ns/1ps
module tb_uart_core_p;
   localparam int BIT_CLK = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic tx_a, tx_b;
`ifdef UART_LOOPBACK_EN
   logic lb_off = 1'b0;
`endif

   int n_cmp = 0;
   int n_mis = 0;
   int fe_cnt [2];
   int pe_cnt [2];
   int ov_cnt [2];
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_core_p_if #(.DATA_BITS(8)) bus_a ();
   uart_core_p_if #(.DATA_BITS(8)) bus_b ();

   uart_core_p #(.CLK_FREQ(8_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(8),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(rx_a), .tx(tx_a), .bus(bus_a)
`ifdef UART_LOOPBACK_EN
      , .loopback(lb_off)
`endif
   );

   uart_core_p #(.CLK_FREQ(8_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(8),
                 .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx(rx_b), .tx(tx_b), .bus(bus_b)
`ifdef UART_LOOPBACK_EN
      , .loopback(lb_off)
`endif
   );

   initial begin
      for (int i = 0; i < 2; i++) begin
         fe_cnt[i] = 0; pe_cnt[i] = 0; ov_cnt[i] = 0;
      end
   end

   always @(posedge clk) begin
      if (bus_a.rx_frame_err)  fe_cnt[0] <= fe_cnt[0] + 1;
      if (bus_a.rx_parity_err) pe_cnt[0] <= pe_cnt[0] + 1;
      if (bus_a.rx_overrun)    ov_cnt[0] <= ov_cnt[0] + 1;
      if (bus_b.rx_frame_err)  fe_cnt[1] <= fe_cnt[1] + 1;
      if (bus_b.rx_parity_err) pe_cnt[1] <= pe_cnt[1] + 1;
      if (bus_b.rx_overrun)    ov_cnt[1] <= ov_cnt[1] + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int par_mode(input int inst);  return (inst == 0) ? 0 : 2; endfunction
   function automatic int stop_cnt(input int inst);  return (inst == 0) ? 1 : 2; endfunction
   function automatic logic tx_line(input int inst);  return (inst == 0) ? tx_a : tx_b; endfunction
   function automatic logic tx_rdy(input int inst);   return (inst == 0) ? bus_a.tx_ready : bus_b.tx_ready; endfunction
   function automatic logic rx_vld(input int inst);   return (inst == 0) ? bus_a.rx_valid : bus_b.rx_valid; endfunction
   function automatic logic [7:0] rx_dat(input int inst); return (inst == 0) ? bus_a.rx_data : bus_b.rx_data; endfunction

   // Reference frame: bit i of the result is the i-th bit on the line.
   function automatic int make_frame(input logic [7:0] d, input int par, input int stops,
                                     output logic [15:0] bits);
      int n, ones;
      bits = '0; bits[0] = 1'b0; n = 1; ones = 0;
      for (int i = 0; i < 8; i++) begin
         bits[n] = d[i]; ones += int'(d[i]); n++;
      end
      if (par != 0) begin
         bits[n] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
         n++;
      end
      for (int i = 0; i < stops; i++) begin
         bits[n] = 1'b1; n++;
      end
      return n;
   endfunction

   task automatic set_rx(input int inst, input logic v);
      if (inst == 0) rx_a = v; else rx_b = v;
   endtask

   task automatic set_tx(input int inst, input logic v, input logic [7:0] d);
      if (inst == 0) begin bus_a.tx_valid = v; bus_a.tx_data = d; end
      else           begin bus_b.tx_valid = v; bus_b.tx_data = d; end
   endtask

   task automatic drive_rx(input int inst, input logic [7:0] d, input bit flip_par, input bit zero_stop);
      logic [15:0] b;
      int n;
      n = make_frame(d, par_mode(inst), stop_cnt(inst), b);
      if (flip_par) b[9] = ~b[9];
      if (zero_stop) b[n - stop_cnt(inst)] = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); set_rx(inst, b[i]);
         repeat (BIT_CLK - 1) @(negedge clk);
      end
      @(negedge clk); set_rx(inst, 1'b1);
      repeat (2 * BIT_CLK) @(negedge clk);
   endtask

   task automatic read_rx(input int inst);
      @(negedge clk);
      if (inst == 0) bus_a.rx_ready = 1'b1; else bus_b.rx_ready = 1'b1;
      @(negedge clk);
      if (inst == 0) bus_a.rx_ready = 1'b0; else bus_b.rx_ready = 1'b0;
   endtask

   // Returns at the negedge just after the accepting posedge.
   task automatic wait_accept(input int inst, output bit ok);
      int w;
      ok = 1'b0; w = 0;
      while (!tx_rdy(inst) && w < 400) begin @(negedge clk); w++; end
      ok = tx_rdy(inst);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic decode_tx(input int inst, input int n, output logic [15:0] bits,
                            output time t0, output bit ok);
      int w;
      ok = 1'b0; bits = '0; w = 0; t0 = 0;
      while (tx_line(inst) !== 1'b0 && w < 400) begin @(negedge clk); w++; end
      if (tx_line(inst) === 1'b0) begin
         ok = 1'b1; t0 = $time;
         repeat (3) @(negedge clk);
         for (int i = 0; i < n; i++) begin
            bits[i] = tx_line(inst);
            if (i < n - 1) repeat (BIT_CLK) @(negedge clk);
         end
      end
   endtask

   task automatic count_ready_low(input int inst, output int c);
      c = 0;
      while (!tx_rdy(inst) && c < 300) begin c++; @(negedge clk); end
   endtask

   task automatic tx_check(input int inst, input logic [7:0] d, input string tag);
      logic [15:0] exp_b, got_b;
      int n, low;
      bit ok_a, ok_d;
      time t0;
      n = make_frame(d, par_mode(inst), stop_cnt(inst), exp_b);
      @(negedge clk); set_tx(inst, 1'b1, d);
      wait_accept(inst, ok_a);
      set_tx(inst, 1'b0, 8'h00);
      fork
         decode_tx(inst, n, got_b, t0, ok_d);
         count_ready_low(inst, low);
      join
      check_eq({tag, "_accept"}, 32'(ok_a), 1);
      check_eq({tag, "_start"}, 32'(ok_d), 1);
      check_eq({tag, "_frame"}, 32'(got_b), 32'(exp_b));
      check_eq({tag, "_busy_clk"}, low, n * BIT_CLK);
   endtask

   task automatic rx_check(input int inst, input logic [7:0] d, input bit flip_par, input bit zero_stop,
                           input int exp_fe, input int exp_pe, input string tag);
      int fe0, pe0, ov0;
      fe0 = fe_cnt[inst]; pe0 = pe_cnt[inst]; ov0 = ov_cnt[inst];
      drive_rx(inst, d, flip_par, zero_stop);
      check_eq({tag, "_valid"}, 32'(rx_vld(inst)), 1);
      check_eq({tag, "_data"}, 32'(rx_dat(inst)), 32'(d));
      check_eq({tag, "_ferr"}, fe_cnt[inst] - fe0, exp_fe);
      check_eq({tag, "_perr"}, pe_cnt[inst] - pe0, exp_pe);
      check_eq({tag, "_ovr"}, ov_cnt[inst] - ov0, 0);
      read_rx(inst);
      check_eq({tag, "_cleared"}, 32'(rx_vld(inst)), 0);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic [15:0] f1, f2, e1, e2;
      time t1, t2;
      bit ok1, ok2, oka, okb;
      int fe0, ov0, n;
      logic [7:0] b1, b2;

      bus_a.tx_valid = 1'b0; bus_a.tx_data = '0; bus_a.rx_ready = 1'b0;
      bus_b.tx_valid = 1'b0; bus_b.tx_data = '0; bus_b.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx", 32'(tx_a), 1);
      check_eq("rst_tx_ready", 32'(bus_a.tx_ready), 0);
      check_eq("rst_rx_valid", 32'(bus_a.rx_valid), 0);
      check_eq("rst_rx_data", 32'(bus_a.rx_data), 0);
      check_eq("rst_pulses", 32'({bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_overrun}), 0);
      check_eq("rst_tx_b", 32'(tx_b), 1);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready_a", 32'(bus_a.tx_ready), 1);
      check_eq("post_rst_ready_b", 32'(bus_b.tx_ready), 1);

      tx_check(0, 8'hA5, "txA5");
      for (int i = 0; i < 3; i++) tx_check(0, 8'($urandom_range(0, 255)), "tx_rand");

      rx_check(0, 8'h3C, 1'b0, 1'b0, 0, 0, "rx3C");
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(d);
         drive_rx(0, d, 1'b0, 1'b0);
         check_eq("rx_rand_valid", 32'(bus_a.rx_valid), 1);
         check_eq("rx_rand_data", 32'(bus_a.rx_data), 32'(exp_q.pop_front()));
         read_rx(0);
      end

      rx_check(0, 8'h55, 1'b0, 1'b1, 1, 0, "rx_ferr55");

      fe0 = fe_cnt[0];
      @(negedge clk); rx_a = 1'b0;
      repeat (2) @(negedge clk); rx_a = 1'b1;
      repeat (5 * BIT_CLK) @(negedge clk);
      check_eq("glitch_valid", 32'(bus_a.rx_valid), 0);
      check_eq("glitch_ferr", fe_cnt[0] - fe0, 0);

      ov0 = ov_cnt[0];
      drive_rx(0, 8'h11, 1'b0, 1'b0);
      drive_rx(0, 8'h22, 1'b0, 1'b0);
      check_eq("ovr_valid", 32'(bus_a.rx_valid), 1);
      check_eq("ovr_data", 32'(bus_a.rx_data), 32'h11);
      check_eq("ovr_pulses", ov_cnt[0] - ov0, 1);
      read_rx(0);

      rx_check(1, 8'h07, 1'b1, 1'b0, 0, 1, "rxB_perr07");
      for (int i = 0; i < 3; i++) rx_check(1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 0, 0, "rxB_rand");
      tx_check(1, 8'h07, "txB07");
      tx_check(1, 8'($urandom_range(0, 255)), "txB_rand");

      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      n = make_frame(b1, 0, 1, e1);
      n = make_frame(b2, 0, 1, e2);
      fork
         begin
            @(negedge clk); set_tx(0, 1'b1, b1);
            wait_accept(0, oka);
            set_tx(0, 1'b1, b2);
            wait_accept(0, okb);
            set_tx(0, 1'b0, 8'h00);
         end
         begin
            decode_tx(0, n, f1, t1, ok1);
            decode_tx(0, n, f2, t2, ok2);
         end
      join
      check_eq("b2b_accept", 32'({oka, okb, ok1, ok2}), 32'hF);
      check_eq("b2b_frame1", 32'(f1), 32'(e1));
      check_eq("b2b_frame2", 32'(f2), 32'(e2));
      check_eq("b2b_gap_ok", 32'((t2 - t1) <= 810 && (t2 - t1) >= 800), 1);

      @(negedge clk); set_tx(0, 1'b1, 8'hF0);
      wait_accept(0, oka);
      set_tx(0, 1'b0, 8'h00);
      repeat (35) @(negedge clk);
      check_eq("midtx_bit3", 32'(tx_a), 0);
      reset_n = 1'b0;
      #1;
      check_eq("midtx_rst_tx", 32'(tx_a), 1);
      check_eq("midtx_rst_ready", 32'(bus_a.tx_ready), 0);
      check_eq("midtx_rst_rxdata", 32'(bus_a.rx_data), 0);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      check_eq("midtx_ready_back", 32'(bus_a.tx_ready), 1);
      tx_check(0, 8'($urandom_range(0, 255)), "tx_after_rst");

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/uart_core_p.md
Name: uart_core_p

Overview:
- Parametrised successor to the calculator's fixed 8N1 UART.
- Configurable data width, parity and stop bits; oversampled, synchronised RX with majority voting; framing/parity/overrun error reporting; valid/ready handshakes on both directions.
- Sits between the pins and the command parser / result formatter.

Parameters:
- CLK_FREQ, 25_000_000, system clock in Hz.
- BAUD_RATE, 115200, line rate in baud.
- OVERSAMPLE, 8, sample ticks per bit; must be ≥4 and even.
- DATA_BITS, 8, payload bits per frame, 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input; asynchronous to clk.
- tx  out  1  serial output; idle high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer accepts rx_data.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_parity_err  out  1  one-cycle pulse: parity mismatch.
- rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid was still high.

Behaviour:

Reset and timing base
- reset_n low, asynchronously:
  - tx=1, tx_ready=0, rx_valid=0, rx_data=0, all error pulses=0.
  - Both FSMs return to IDLE; synchroniser flops and all counters clear.
- tx_ready rises the first clk after reset release.
- Reset mid-frame aborts the frame with no pulses; tx returns high immediately.
- Tick generator: DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded.
  - Free-running counter emits a one-cycle tick every DIV clocks. DIV=1 means a tick every clock.
  - Shared by RX and TX. One bit = OVERSAMPLE ticks.

TX
- FSM: IDLE → START → DATA → PARITY (only if PARITY≠0) → STOP → IDLE.
- A transfer is accepted on a clk where tx_valid && tx_ready. tx_data is latched; tx_ready drops the next cycle.
- START drives 0 beginning at the first tick after acceptance.
- DATA is sent LSB first. PARITY sends XOR of the data bits, inverted for odd.
- STOP drives 1 for STOP_BITS×OVERSAMPLE ticks.
- tx_ready returns high in the same cycle the FSM re-enters IDLE.
- Back-to-back: a byte may be accepted in that same cycle, so no extra idle bits are inserted.
- tx_valid held with tx_ready low has no effect.

RX
- rx passes through a 2-flop synchroniser; all RX logic uses the synchronised value.
- FSM: IDLE → START → DATA → PARITY (only if PARITY≠0) → STOP → IDLE.
- IDLE: a falling edge (1→0) on the synchronised rx moves the FSM to START and zeroes the tick counter.
- START: at tick OVERSAMPLE/2, if the majority vote is 1 the start is false and the FSM returns to IDLE silently.
- Majority vote = 2-of-3 over samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 of each bit. Every later bit is sampled by vote at its mid-point.
- Data shifts in LSB first.
- Only the first stop bit is checked. The FSM returns to IDLE at the mid-point of the first stop bit, so it can resync on the next start edge.
- Frame completion, at the STOP mid-point:
  - rx_valid=0: rx_data ← shifted byte; rx_valid ← 1.
  - rx_valid=1: the new byte is dropped, the old byte is kept, rx_overrun pulses.
  - rx_frame_err and rx_parity_err pulse in the same cycle as completion, in either case.
  - A byte with errors is still delivered.
- rx_valid clears on the clk after rx_valid && rx_ready.
- If a read and a completion land in the same cycle, the new byte is loaded, rx_valid stays 1, and there is no overrun.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit).
  - loopback=1: the RX path takes the TX serial output internally (ahead of the synchroniser) instead of rx, and the tx pin is held at 1.
  - loopback=0: normal operation.
- Undefined: the port is absent; RX always uses rx.

Test Plan:
Bench config: CLK_FREQ=8_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=8, so DIV=1 and one bit = 8 clk.
- 8N1 TX: send 0xA5 → tx reads 0,1,0,1,0,0,1,0,1,1, 8 clk per bit. tx_ready low for 80 clk, then high.
- 8N1 RX: drive frame 0x3C on rx → rx_valid rises ~3 clk (synchroniser plus sample point) after the stop mid-point with rx_data=0x3C. No error pulses.
- PARITY=2, STOP_BITS=2: drive 0x07 with parity bit 0 → rx_data=0x07 and rx_parity_err pulses once. Send 0x07 on TX → parity bit 1, two stop bits, frame = 12 bits = 96 clk.
- Frame error and glitch: 0x55 with stop bit forced 0 → rx_frame_err pulse and rx_data=0x55. A 2-clk low glitch in idle → no rx_valid.
- Overrun and back-to-back: two RX frames 0x11, 0x22 with rx_ready=0 → rx_data=0x11 and one rx_overrun pulse. With tx_valid held high, two TX bytes go out with no idle gap.
- Reset mid-TX: assert reset_n low during DATA bit 3 → tx=1 immediately. After release, tx_ready=1 within 1 clk and the next byte transmits correctly.
